// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle logic/arith, iterative mul/div with start/busy/done
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         ALU_FUNC,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               OF_detect,
  output logic               div_by_zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state, next_state;
  logic [2:0]         func_q;
  logic [WIDTH-1:0]   op_a, op_b;
  // acc_hi/acc_lo: product high/low halves for mul, remainder/quotient for div
  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic [CNT_W-1:0]   cnt;
  // a short op was accepted last edge and completes on this one
  logic               pend;
  logic [2*WIDTH-1:0] out_q;
  logic               of_q, dbz_q, done_q;

  logic accept, long_op, last_iter, is_mul;
  assign accept    = start && (state == IDLE);
  assign long_op   = (ALU_FUNC == OP_MUL) || ((ALU_FUNC == OP_DIV) && (b != '0));
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign is_mul    = (func_q == OP_MUL);

  // one shift-add or restoring-divide step computed from the current accumulators
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_sub, iter_hi, iter_lo;
  logic             div_ge;
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, op_b});
    // the true difference fits in WIDTH bits whenever div_ge holds
    div_sub   = div_shift[WIDTH-1:0] - op_b;
    if (is_mul) begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      iter_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      iter_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  // single-cycle results from the latched operands
  logic [WIDTH:0]     add_sum, sub_diff;
  logic [2*WIDTH-1:0] fast_out;
  logic               fast_of, fast_dbz;
  always_comb begin
    add_sum  = {1'b0, op_a} + {1'b0, op_b};
    sub_diff = {1'b0, op_a} - {1'b0, op_b};
    fast_out = '0;
    fast_of  = 1'b0;
    fast_dbz = 1'b0;
    case (func_q)
      OP_ADD: begin
        fast_out = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
        fast_of  = add_sum[WIDTH];
      end
      OP_SUB: begin
        fast_out = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
        fast_of  = sub_diff[WIDTH];
      end
      OP_AND: fast_out = {{WIDTH{1'b0}}, op_a & op_b};
      OP_OR:  fast_out = {{WIDTH{1'b0}}, op_a | op_b};
      // only a zero divisor reaches the short path for div
      OP_DIV: begin
        fast_out = {op_a, {WIDTH{1'b1}}};
        fast_dbz = 1'b1;
      end
      default: fast_out = '0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept && long_op) next_state = CALC;
      CALC: if (last_iter)         next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == CALC);
  end

  // operand capture, iteration and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      func_q <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      pend   <= 1'b0;
      out_q  <= '0;
      of_q   <= 1'b0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pend) begin
        out_q  <= fast_out;
        of_q   <= fast_of;
        dbz_q  <= fast_dbz;
        done_q <= 1'b1;
        pend   <= 1'b0;
      end
      if (state == CALC) begin
        acc_hi <= iter_hi;
        acc_lo <= iter_lo;
        cnt    <= cnt + CNT_W'(1);
        if (last_iter) begin
          out_q  <= {iter_hi, iter_lo};
          of_q   <= 1'b0;
          dbz_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
      // a new accept in the same edge as a short completion overrides pend
      if (accept) begin
        func_q <= ALU_FUNC;
        op_a   <= a;
        op_b   <= b;
        acc_hi <= '0;
        acc_lo <= a;
        cnt    <= '0;
        pend   <= ~long_op;
      end
    end
  end

  assign done        = done_q;
  assign out         = out_q;
  assign OF_detect   = of_q;
  assign div_by_zero = dbz_q;

endmodule
